alu_result_queue: RTL and testbench

Registered buffer directly downstream of the 16-bit combinational ALU (op[2:0], a, b -> Result, zero, co, overflow). Each valid ALU result, its three flags and a destination-register tag are captured into a small FIFO. Entries drain to the writeback stage over a valid/ready handshake. On each drain, a processor status register (Z, C, V) is updated and a sticky overflow bit is maintained.

---
 rtl/alu_result_queue_if.sv | 45 ++++
 rtl/alu_result_queue.sv | 113 +++++++++++
 tb/tb_alu_result_queue.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_result_queue_if.sv
// Handshake bundle between the ALU, the result queue and the writeback stage.
// slave: the queue's view. master: the surrounding pipeline's view.
interface alu_result_queue_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned TAG_BITS = 4,
    parameter int unsigned DEPTH    = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_result;
    logic                in_zero;
    logic                in_co;
    logic                in_overflow;
    logic [TAG_BITS-1:0] in_tag;

    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_result;
    logic [TAG_BITS-1:0] out_tag;

    logic [2:0]          status;
    logic                ovf_sticky;
    logic                clr_sticky;
    logic [CW-1:0]       count;

    modport slave (
        input  in_valid, in_result, in_zero, in_co, in_overflow, in_tag,
        output in_ready,
        output out_valid, out_result, out_tag,
        input  out_ready,
        output status, ovf_sticky, count,
        input  clr_sticky
    );

    modport master (
        output in_valid, in_result, in_zero, in_co, in_overflow, in_tag,
        input  in_ready,
        input  out_valid, out_result, out_tag,
        output out_ready,
        input  status, ovf_sticky, count,
        output clr_sticky
    );
endinterface

// File: rtl/alu_result_queue.sv
// FIFO of ALU results + flags + destination tag, drained over valid/ready.
// Each drain updates the {Z,C,V} status register and a sticky overflow bit.
module alu_result_queue #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned TAG_BITS = 4,
    parameter int unsigned DEPTH    = 4
) (
    input logic                clk,
    input logic                reset,
    alu_result_queue_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [CW-1:0] FullCount = CW'(DEPTH);
    localparam logic [CW-1:0] CntOne    = CW'(1);
    localparam logic [PW-1:0] PtrOne    = PW'(1);

    typedef struct packed {
        logic [WIDTH-1:0]    result;
        logic                zero;
        logic                co;
        logic                overflow;
        logic [TAG_BITS-1:0] tag;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    status_q, status_d;
    logic          sticky_q, sticky_d;

    logic   full, empty, push, pop;
    entry_t head, in_entry;

    assign full     = (count_q == FullCount);
    assign empty    = (count_q == '0);
    assign push     = bus.in_valid && !full;
    assign pop      = bus.out_ready && !empty;
    assign head     = mem_q[rd_ptr_q];
    assign in_entry = '{result:   bus.in_result,
                        zero:     bus.in_zero,
                        co:       bus.in_co,
                        overflow: bus.in_overflow,
                        tag:      bus.in_tag};

    // Next-state: storage write, pointer/count update, status and sticky tracking.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        status_d = status_q;
        sticky_d = sticky_q;

        // in_* is only looked at on a push, so X on idle inputs never lands in storage.
        if (push) begin
            mem_d[wr_ptr_q] = in_entry;
            wr_ptr_d        = wr_ptr_q + PtrOne;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
            status_d = {head.zero, head.co, head.overflow};
        end

        if (push && !pop) begin
            count_d = count_q + CntOne;
        end else if (pop && !push) begin
            count_d = count_q - CntOne;
        end

        // A V=1 drain overrides a clear in the same cycle.
        if (bus.clr_sticky) begin
            sticky_d = 1'b0;
        end
        if (pop && head.overflow) begin
            sticky_d = 1'b1;
        end
    end

    // Control state; reset discards all queued entries at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            status_q <= 3'b000;
            sticky_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            status_q <= status_d;
            sticky_q <= sticky_d;
        end
    end

    // Payload storage; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready   = !full;
    assign bus.out_valid  = !empty;
    assign bus.out_result = head.result;
    assign bus.out_tag    = head.tag;
    assign bus.status     = status_q;
    assign bus.ovf_sticky = sticky_q;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_alu_result_queue.sv
// Randomized + directed bench for alu_result_queue against a queue-based model.
module tb_alu_result_queue;
    localparam int unsigned WIDTH    = 16;
    localparam int unsigned TAG_BITS = 4;
    localparam int unsigned DEPTH    = 4;

    typedef struct packed {
        logic [WIDTH-1:0]    r;
        logic                z;
        logic                c;
        logic                v;
        logic [TAG_BITS-1:0] tag;
    } ent_t;

    logic clk = 1'b0;
    logic reset;

    alu_result_queue_if #(.WIDTH(WIDTH), .TAG_BITS(TAG_BITS), .DEPTH(DEPTH)) bus ();

    alu_result_queue #(.WIDTH(WIDTH), .TAG_BITS(TAG_BITS), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_bad   = 0;
    ent_t mq[$];
    logic [2:0] m_status = 3'b000;
    logic       m_sticky = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] r, input logic z, input logic c,
                         input logic ov, input logic [3:0] tag, input logic rdy);
        bus.in_valid    = v;
        bus.in_result   = r;
        bus.in_zero     = z;
        bus.in_co       = c;
        bus.in_overflow = ov;
        bus.in_tag      = tag;
        bus.out_ready   = rdy;
    endtask

    // Advance one clock, update the model from the inputs presented, compare everything.
    task automatic step();
        bit   push, pop, clr;
        ent_t e, head;
        push = bus.in_valid && (mq.size() < DEPTH);
        pop  = bus.out_ready && (mq.size() > 0);
        clr  = bus.clr_sticky;
        e    = '{r: bus.in_result, z: bus.in_zero, c: bus.in_co, v: bus.in_overflow,
                 tag: bus.in_tag};
        @(posedge clk);
        if (clr) m_sticky = 1'b0;
        if (pop) begin
            head     = mq.pop_front();
            m_status = {head.z, head.c, head.v};
            if (head.v) m_sticky = 1'b1;
        end
        if (push) mq.push_back(e);
        #1;
        chk("count", 32'(bus.count), mq.size());
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
        chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
        chk("status", 32'(bus.status), 32'(m_status));
        chk("ovf_sticky", 32'(bus.ovf_sticky), 32'(m_sticky));
        if (mq.size() > 0) begin
            chk("out_result", 32'(bus.out_result), 32'(mq[0].r));
            chk("out_tag", 32'(bus.out_tag), 32'(mq[0].tag));
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.clr_sticky = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        #12;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_status", 32'(bus.status), 0);
        chk("rst_sticky", 32'(bus.ovf_sticky), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: single push, visible one cycle later
        drive(1'b1, 16'd220, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        chk("t1_result", 32'(bus.out_result), 220);
        chk("t1_tag", 32'(bus.out_tag), 3);
        chk("t1_count", 32'(bus.count), 1);
        step();

        // 2: fill, overflowed push dropped, drain in order
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(100 + i), 1'b0, 1'b0, 1'b0, 4'(i), 1'b0);
            step();
        end
        chk("t2_full_ready", 32'(bus.in_ready), 0);
        drive(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
        step();
        chk("t2_full_count", 32'(bus.count), 4);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 4; i++) step();
        chk("t2_empty_valid", 32'(bus.out_valid), 0);
        step();

        // 3: steady push+pop at count=2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'(500 + i), 1'b0, 1'b0, 1'b0, 4'(i), 1'b0);
            step();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'(600 + i), 1'b0, 1'b0, 1'b0, 4'(i), 1'b1);
            step();
            chk("t3_count", 32'(bus.count), 2);
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        step(); step();

        // 4: status/sticky sequence, then clear
        drive(1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0);
        step();
        drive(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        step();
        chk("t4_status1", 32'(bus.status), 3'b011);
        step();
        chk("t4_status2", 32'(bus.status), 3'b110);
        chk("t4_sticky", 32'(bus.ovf_sticky), 1);
        step();
        bus.clr_sticky = 1'b1;
        step();
        bus.clr_sticky = 1'b0;
        chk("t4_cleared", 32'(bus.ovf_sticky), 0);

        // 5: clear and V=1 pop on the same edge -> set wins
        drive(1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        bus.clr_sticky = 1'b1;
        step();
        bus.clr_sticky = 1'b0;
        chk("t5_set_wins", 32'(bus.ovf_sticky), 1);

        // 6: async reset between edges with 3 entries queued
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(900 + i), 1'b0, 1'b0, 1'b0, 4'(i), 1'b0);
            step();
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("t6_count", 32'(bus.count), 0);
        chk("t6_out_valid", 32'(bus.out_valid), 0);
        chk("t6_in_ready", 32'(bus.in_ready), 1);
        chk("t6_status", 32'(bus.status), 0);
        chk("t6_sticky", 32'(bus.ovf_sticky), 0);
        #1 reset = 1'b0;
        mq.delete();
        m_status = 3'b000;
        m_sticky = 1'b0;
        drive(1'b1, 16'd7, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0);
        step();
        chk("t6_first_out", 32'(bus.out_result), 7);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) == 0), 4'($urandom), 1'($urandom_range(0, 2) != 0));
            bus.clr_sticky = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
